fft_io_host: RTL and testbench
==============================

# fft_io_host

Host-side initiator for the FFT core's bidirectional data port. It streams one frame of FRAME_LEN samples from a valid/ready source onto `ext_bidir_port` and generates the chip-select, direction and tristate controls that make the core's IO block capture each sample. After the core signals `fft_done`, it turns the bus around, reads the transformed frame back off the same port, and delivers it on a valid/ready sink. It sits between the board-level host logic and the FFT core's IO block.

## Interface
- `FFT_DATA_WIDTH`, 16 (from shared defines): sample width.
- `FRAME_LEN`, 64: samples per frame, power of two.
- `ADDR_W`, 6: log2(FRAME_LEN).
- `OFIFO_DEPTH`, 4: output buffer depth.

Ports:
- `io_clock  in  1`: single clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: begin a frame; sampled only in IDLE.
- `in_data  in  FFT_DATA_WIDTH`, `in_valid  in  1`, `in_ready  out  1`: sample source.
- `out_data  out  FFT_DATA_WIDTH`, `out_valid  out  1`, `out_ready  in  1`: result sink.
- `fft_done  in  1`: core finished the transform; honoured only in WAIT_DONE.
- `core_addr  out  ADDR_W`: sample index for the core.
- `core_load  out  1`: core writes `data_2b_input` at `core_addr` this cycle.
- `busy  out  1`: state != IDLE.
- `frame_done  out  1`: one-cycle pulse when returning to IDLE.
- `ext_bidir_port  inout  FFT_DATA_WIDTH`: shared data bus.
- `c_chip_select`, `c_ext_write`, `c_tri_data_2b_input`, `c_tri_data_2b_output  out  1`: IO-block controls.

## Operation
States are IDLE, LOAD, WAIT_DONE, TURN, UNLOAD, DRAIN.

- **IDLE**
  - All controls are inactive and the port is Z.
  - `start` moves to LOAD and clears both indices.
- **LOAD**
  - `in_ready` = 1.
  - On an `in_valid & in_ready` cycle: drive `ext_bidir_port` = `in_data`, with `c_chip_select` = 1 and `c_ext_write` = 0.
  - In the following cycle: `core_load` = 1, `c_tri_data_2b_input` = 0, and `core_addr` = index of that sample.
  - The port is Z on any cycle without a handshake.
  - After accepting index FRAME_LEN-1, move to WAIT_DONE. The trailing `core_load` still fires in WAIT_DONE's first cycle.
- **WAIT_DONE**
  - The port is Z and `c_chip_select` = 0.
  - `fft_done` moves to TURN.
- **TURN**
  - Exactly one cycle with all drivers released.
  - Then move to UNLOAD.
- **UNLOAD**
  - Issue a read when `ofifo_count + pending < OFIFO_DEPTH`.
  - A read cycle has `c_chip_select` = 1, `c_ext_write` = 1, `core_addr` = read index, and sets the `pending` flag.
  - The host never drives the port in UNLOAD or DRAIN.
  - The cycle after an issue, the port is captured into the output FIFO at the rising edge, and `pending` clears.
  - After issuing index FRAME_LEN-1, move to DRAIN.
- **DRAIN**
  - No issues.
  - When `pending` = 0 and the FIFO is empty: pulse `frame_done` and return to IDLE.
- **Tristate control**
  - `c_tri_data_2b_output` = 0 iff state == UNLOAD or `pending` = 1.
  - `c_tri_data_2b_input` = 0 only on `core_load` cycles.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `fft_done` outside WAIT_DONE is ignored.
- **Output FIFO**
  - `out_valid` = FIFO not empty; `out_data` = head.
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle are both allowed.
- **Reset (`reset_n` low, at any time including mid-frame)**
  - State returns to IDLE and indices/FIFO are cleared.
  - Outputs: `c_chip_select` = 0, `c_ext_write` = 0, both tri controls = 1, port = Z, `in_ready` = 0, `out_valid` = 0, `core_load` = 0, `core_addr` = 0, `busy` = 0, `frame_done` = 0.

## Timing
- **Load:**
  - Handshake in cycle k.
  - The IO block captures at the end of cycle k.
  - `core_load` is high in cycle k+1.
  - Throughput is 1 sample per cycle.
- **Unload:**
  - Issue in cycle k; the IO register loads at the end of cycle k.
  - The port is valid in cycle k+1; the FIFO captures at the end of cycle k+1.
  - `out_valid` is high in cycle k+2.
  - Latency is 2 cycles. With `out_ready` held high, throughput is 1 sample per cycle.
- **Bus turnaround:** the host never drives the port in the same cycle as, or the cycle adjacent to, an IO-block drive cycle (TURN guarantees this).
- **Backpressure:** with `out_ready` low, at most OFIFO_DEPTH reads are outstanding. None are lost, and the sink sees them in order.
- **Core requirement:** the core presents `data_2b_output` for `core_addr` combinationally in the issue cycle.

## Structure
- Shared package holds:
  - the state encoding (IDLE..DRAIN);
  - the default FRAME_LEN;
  - the `FFT_DATA_WIDTH` define, reused as-is.
- Sub-module: `fft_io_ofifo`, a synchronous FIFO of OFIFO_DEPTH x FFT_DATA_WIDTH with count output and async active-low reset.
- The top level holds the FSM, the indices, the pending flag and the tristate driver.

## Test plan
- **Reset mid-LOAD:** assert `reset_n` = 0 after 10 samples → all outputs at reset values, port Z; a new `start` reloads from `core_addr` 0.
- **Full frame, no stalls:**
  - Stimulus: samples 0x0000..0x003F in back-to-back; `fft_done` 5 cycles later; IO model returns ~addr.
  - Response: 64 `core_load` pulses with addr 0..63; output 0xFFFF..0xFFC0 in order; one `frame_done` pulse.
- **Input gaps:** `in_valid` toggles every other cycle → the port is Z on idle cycles; `core_load` count = 64.
- **Output backpressure:** `out_ready` held low for 20 cycles during UNLOAD → `pending` + FIFO never exceeds 4; no sample lost or duplicated.
- **Spurious controls:** `start` and `fft_done` pulsed during LOAD → ignored; `fft_done` in WAIT_DONE → exactly one TURN cycle with port Z and `c_chip_select` = 0.
- **Bus contention check:** assertion that host-drive and IO-drive (`c_tri_data_2b_output` low in the previous cycle) are never true together across the full frame.

Source files
------------

// File: rtl/fft_io_host_pkg.sv
// Shared types and defaults for the FFT core host-side IO initiator.
// Holds the FSM state encoding and the default frame geometry.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

package fft_io_host_pkg;

    localparam int FFT_DW        = `FFT_DATA_WIDTH;
    localparam int FRAME_LEN_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_TURN,
        ST_UNLOAD,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/fft_io_ofifo.sv
// Small synchronous output FIFO with occupancy count.
// Absorbs read-back samples while the sink applies backpressure.
module fft_io_ofifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = i_push && (r_count != LP_FULL);
    assign w_rd    = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= (r_wptr == LP_LAST) ? '0 : r_wptr + PTR_W'(1);
            if (w_rd) r_rptr <= (r_rptr == LP_LAST) ? '0 : r_rptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fft_io_host.sv
// Host-side initiator: streams a frame into the FFT core over the shared
// bidirectional port, waits for the transform, then reads the result back.
module fft_io_host
    import fft_io_host_pkg::*;
#(
    parameter int FFT_DATA_WIDTH = FFT_DW,
    parameter int FRAME_LEN      = FRAME_LEN_DEF,
    parameter int ADDR_W         = $clog2(FRAME_LEN),
    parameter int OFIFO_DEPTH    = 4
) (
    input  logic                      io_clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [FFT_DATA_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [FFT_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      fft_done,
    output logic [ADDR_W-1:0]         core_addr,
    output logic                      core_load,
    output logic                      busy,
    output logic                      frame_done,
    inout  wire  [FFT_DATA_WIDTH-1:0] ext_bidir_port,
    output logic                      c_chip_select,
    output logic                      c_ext_write,
    output logic                      c_tri_data_2b_input,
    output logic                      c_tri_data_2b_output
);

    localparam int CNT_W = $clog2(OFIFO_DEPTH + 1);
    localparam logic [CNT_W:0]    LP_DEPTH = (CNT_W + 1)'(OFIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(FRAME_LEN - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_widx;
    logic [ADDR_W-1:0] r_ridx;
    logic [ADDR_W-1:0] r_load_addr;
    logic              r_load;
    logic              r_pending;
    logic              w_acc;
    logic              w_issue;
    logic              w_pop;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occ;

    assign w_occ   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_pending};
    assign w_acc   = in_valid && in_ready;
    assign w_issue = (r_state == ST_UNLOAD) && (w_occ < LP_DEPTH);
    assign w_pop   = out_valid && out_ready;

    always_ff @(posedge io_clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        unique case (r_state)
            ST_IDLE:      if (start) w_next = ST_LOAD;
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_widx == LP_LAST) w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (fft_done) w_next = ST_TURN;
            ST_TURN:      w_next = ST_UNLOAD;
            ST_UNLOAD:    if (w_issue && r_ridx == LP_LAST) w_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!r_pending && w_empty) begin
                    frame_done = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default:      w_next = ST_IDLE;
        endcase
    end

    // core_load trails the handshake by one cycle, so remember its index
    always_ff @(posedge io_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_widx      <= '0;
            r_ridx      <= '0;
            r_load_addr <= '0;
            r_load      <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_load    <= w_acc;
            r_pending <= w_issue;
            if (w_acc) r_load_addr <= r_widx;
            if (r_state == ST_IDLE && start) begin
                r_widx <= '0;
                r_ridx <= '0;
            end else begin
                if (w_acc)   r_widx <= r_widx + ADDR_W'(1);
                if (w_issue) r_ridx <= r_ridx + ADDR_W'(1);
            end
        end
    end

    assign busy                 = (r_state != ST_IDLE);
    assign core_load            = r_load;
    assign c_chip_select        = w_acc | w_issue;
    assign c_ext_write          = w_issue;
    assign c_tri_data_2b_input  = ~r_load;
    assign c_tri_data_2b_output = ~((r_state == ST_UNLOAD) | r_pending);
    assign core_addr            = r_load  ? r_load_addr :
                                  w_issue ? r_ridx : '0;
    assign out_valid            = ~w_empty;
    assign ext_bidir_port       = w_acc ? in_data : {FFT_DATA_WIDTH{1'bz}};

    fft_io_ofifo #(
        .W     (FFT_DATA_WIDTH),
        .DEPTH (OFIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_ofifo (
        .clk     (io_clock),
        .rst_n   (reset_n),
        .i_push  (r_pending),
        .i_data  (ext_bidir_port),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_fft_io_host.sv
// Bench for fft_io_host: behavioural FFT IO block plus a frame-level
// reference (each result is the bitwise inverse of the sample, in order).
module tb_fft_io_host;

    localparam int DW    = 16;
    localparam int FL    = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] ZZ = {DW{1'bz}};

    logic          io_clock  = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          fft_done  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [DW-1:0] out_data;
    logic          in_ready, out_valid, core_load, busy, frame_done;
    logic          cs, ew, tri_in, tri_out;
    logic [AW-1:0] core_addr;
    wire  [DW-1:0] ext_bidir_port;

    int checks   = 0;
    int failures = 0;

    always #5 io_clock = ~io_clock;

    fft_io_host #(
        .FFT_DATA_WIDTH (DW),
        .FRAME_LEN      (FL),
        .ADDR_W         (AW),
        .OFIFO_DEPTH    (DEPTH)
    ) dut (
        .io_clock             (io_clock),
        .reset_n              (reset_n),
        .start                (start),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .out_data             (out_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .fft_done             (fft_done),
        .core_addr            (core_addr),
        .core_load            (core_load),
        .busy                 (busy),
        .frame_done           (frame_done),
        .ext_bidir_port       (ext_bidir_port),
        .c_chip_select        (cs),
        .c_ext_write          (ew),
        .c_tri_data_2b_input  (tri_in),
        .c_tri_data_2b_output (tri_out)
    );

    // FFT IO block: capture on write, store inverse on load, drive on read
    logic [DW-1:0] core_mem [FL];
    logic [DW-1:0] io_cap = '0;
    logic [DW-1:0] io_out = '0;
    logic          io_drv = 1'b0;

    always @(posedge io_clock) begin
        if (cs && !ew)   io_cap <= ext_bidir_port;
        if (core_load)   core_mem[core_addr] <= ~io_cap;
        if (cs && ew)    io_out <= core_mem[core_addr];
        io_drv <= !tri_out;
    end

    assign ext_bidir_port = io_drv ? io_out : ZZ;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] rx_q [$];
    logic [AW-1:0] addr_q [$];
    int fd_cnt, drv_err, z_err, contention, issued, popped, max_occ;

    always @(negedge io_clock) begin
        if (reset_n) begin
            if (core_load) addr_q.push_back(core_addr);
            if (frame_done) fd_cnt++;
            if (in_ready && in_valid && ext_bidir_port !== in_data) drv_err++;
            if (in_ready && !in_valid && ext_bidir_port !== ZZ) z_err++;
            if (cs && !ew && (io_drv || !tri_out)) contention++;
            if (cs && ew) begin
                issued++;
                if (issued - popped > max_occ) max_occ = issued - popped;
            end
            if (out_valid && out_ready) begin
                popped++;
                rx_q.push_back(out_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        rx_q.delete();
        addr_q.delete();
        fd_cnt = 0; drv_err = 0; z_err = 0; contention = 0;
        issued = 0; popped = 0; max_occ = 0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, " cs"}, 32'(cs), 0);
        chk({tag, " ew"}, 32'(ew), 0);
        chk({tag, " tri_in"}, 32'(tri_in), 1);
        chk({tag, " tri_out"}, 32'(tri_out), 1);
        chk({tag, " port"}, 32'(ext_bidir_port), 32'(ZZ));
        chk({tag, " in_ready"}, 32'(in_ready), 0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " core_load"}, 32'(core_load), 0);
        chk({tag, " core_addr"}, 32'(core_addr), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
    endtask

    // mode 0: sequential, no stalls; 1: gaps + spurious controls;
    // 2: random data + sink stall; 3: random valid and ready
    task automatic run_frame(input int mode, input string nm);
        int n, cyc, bad;
        bit seen;
        clear_mon();
        out_ready = 1'b1;
        @(posedge io_clock); #1 start = 1'b1;
        @(posedge io_clock); #1 start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < FL && cyc < 2000) begin
            case (mode)
                1:       in_valid = (cyc % 2 == 0);
                3:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = 1'b1;
            endcase
            in_data  = (mode == 0) ? DW'(n) : DW'($urandom);
            start    = (mode == 1 && cyc == 7);
            fft_done = (mode == 1 && (cyc == 7 || cyc == 20));
            if (in_valid) exp_q.push_back(~in_data);
            @(posedge io_clock); #1;
            if (in_valid) n++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        fft_done = 1'b0;
        chk({nm, " samples sent"}, 32'(n), FL);
        chk({nm, " in_ready after frame"}, 32'(in_ready), 0);
        repeat (4) @(posedge io_clock);
        #1 fft_done = 1'b1;
        @(negedge io_clock);
        chk({nm, " wait cs"}, 32'(cs), 0);
        chk({nm, " wait port"}, 32'(ext_bidir_port), 32'(ZZ));
        @(posedge io_clock); #1 fft_done = 1'b0;
        @(negedge io_clock);
        chk({nm, " turn port"}, 32'(ext_bidir_port), 32'(ZZ));
        chk({nm, " turn cs"}, 32'(cs), 0);
        chk({nm, " turn tri_out"}, 32'(tri_out), 1);
        chk({nm, " turn busy"}, 32'(busy), 1);
        @(negedge io_clock);
        chk({nm, " first read"}, 32'({cs, ew}), 32'h3);
        chk({nm, " first read addr"}, 32'(core_addr), 0);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 1000) begin
            @(posedge io_clock); #1;
            case (mode)
                2:       out_ready = !(cyc >= 3 && cyc < 23);
                3:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            @(negedge io_clock);
            if (frame_done) seen = 1'b1;
            cyc++;
        end
        chk({nm, " frame_done seen"}, 32'(seen), 1);
        @(posedge io_clock); #1 out_ready = 1'b1;
        @(negedge io_clock);
        chk({nm, " idle busy"}, 32'(busy), 0);
        chk({nm, " idle frame_done"}, 32'(frame_done), 0);
        chk({nm, " frame_done pulses"}, 32'(fd_cnt), 1);
        chk({nm, " core_load count"}, 32'(addr_q.size()), FL);
        bad = 0;
        foreach (addr_q[i]) if (32'(addr_q[i]) != 32'(i)) bad++;
        chk({nm, " load addr order"}, 32'(bad), 0);
        chk({nm, " host drive data"}, 32'(drv_err), 0);
        chk({nm, " port Z in gaps"}, 32'(z_err), 0);
        chk({nm, " bus contention"}, 32'(contention), 0);
        chk({nm, " outstanding le depth"}, 32'(max_occ <= DEPTH), 1);
        if (mode == 2) chk({nm, " outstanding fills"}, 32'(max_occ), DEPTH);
        chk({nm, " rx count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s rx[%0d]", nm, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        clear_mon();
        repeat (3) @(negedge io_clock);
        reset_vals("por");
        @(posedge io_clock); #1 reset_n = 1'b1;

        // abort a frame part way through LOAD
        @(posedge io_clock); #1 start = 1'b1;
        @(posedge io_clock); #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(posedge io_clock); #1;
        end
        chk("midload busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        reset_vals("midload rst");
        @(posedge io_clock); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;

        run_frame(0, "seq");
        run_frame(1, "gaps");
        run_frame(2, "stall");
        run_frame(3, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
